// File: rtl/normalize_grs_sp_if.sv
// normalize_grs_sp_if: input and output handshake bundles of the SP normalizer
interface normalize_grs_sp_if #(parameter int MANT_W = 48, parameter int EXP_W = 11);
  logic in_valid, in_ready, in_sign, in_sticky;
  logic [EXP_W-1:0] in_exp;
  logic [MANT_W-1:0] in_mant;
  logic [2:0] in_rm;
  logic out_valid, out_ready, sign, exp_ovf;
  logic [32:0] exp_frac;
  logic [2:0] guard_bits, rounding_mode;
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, in_rm, out_ready,
    input in_ready, out_valid, exp_frac, guard_bits, sign, rounding_mode, exp_ovf
  );
  modport slave (
    input in_valid, in_sign, in_exp, in_mant, in_sticky, in_rm, out_ready,
    output in_ready, out_valid, exp_frac, guard_bits, sign, rounding_mode, exp_ovf
  );
endinterface

// File: rtl/normalize_grs_sp.sv
// normalize_grs_sp: iterative SP normalizer producing the exp/frac word and GRS bits for the rounder
module normalize_grs_sp #(
  parameter int MANT_W = 48,
  parameter int EXP_W = 11
) (
  input logic clk,
  input logic rst,
  normalize_grs_sp_if.slave io
);
  localparam int EW = EXP_W + 1;
  typedef enum logic [2:0] {IDLE, CHECK, RSHIFT, LSHIFT, DONE} state_t;
  state_t state, state_n;
  logic signed [EW-1:0] e, e_n;
  logic [MANT_W-1:0] m, m_n;
  logic s, s_n, sign_q, ovf_q;
  logic [2:0] rm_q, gb_q;
  logic [32:0] ef_q;
  assign io.in_ready = state == IDLE;
  assign io.out_valid = state == DONE;
  assign io.exp_frac = ef_q;
  assign io.guard_bits = gb_q;
  assign io.sign = sign_q;
  assign io.rounding_mode = rm_q;
  assign io.exp_ovf = ovf_q;
  // next state and one shift step of the working exponent/mantissa/sticky
  always_comb begin
    state_n = state;
    e_n = e;
    m_n = m;
    s_n = s;
    case (state)
      IDLE: if (io.in_valid) begin
        state_n = CHECK;
        e_n = {io.in_exp[EXP_W-1], io.in_exp};
        m_n = io.in_mant;
        s_n = io.in_sticky;
      end
      CHECK: begin
        if (m == '0) state_n = DONE;
        else if (int'(e) <= -MANT_W) begin
          s_n = s | (|m);
          m_n = '0;
          state_n = DONE;
        end else if (m[MANT_W-1]) begin
          m_n = m >> 1;
          e_n = e + EW'(1);
          s_n = s | m[0];
        end else if (int'(e) < 1) state_n = RSHIFT;
        else if (!m[MANT_W-2] && int'(e) > 1) state_n = LSHIFT;
        else state_n = DONE;
      end
      RSHIFT: begin
        m_n = m >> 1;
        s_n = s | m[0];
        e_n = e + EW'(1);
        state_n = e_n == EW'(1) ? DONE : RSHIFT;
      end
      LSHIFT: begin
        m_n = m << 1;
        e_n = e - EW'(1);
        state_n = (m_n[MANT_W-2] || e_n == EW'(1)) ? DONE : LSHIFT;
      end
      DONE: state_n = io.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // state/working registers; result bundle is loaded once on entry to DONE and held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      e <= '0;
      m <= '0;
      s <= 1'b0;
      sign_q <= 1'b0;
      rm_q <= '0;
      ef_q <= '0;
      gb_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      e <= e_n;
      m <= m_n;
      s <= s_n;
      if (state == IDLE && io.in_valid) begin
        sign_q <= io.in_sign;
        rm_q <= io.in_rm;
      end
      if (state_n == DONE && state != DONE) begin
        ef_q <= {m_n[MANT_W-2] ? e_n[9:0] : 10'd0, m_n[MANT_W-3 -: 23]};
        gb_q <= {m_n[MANT_W-26], m_n[MANT_W-27], (|m_n[MANT_W-28:0]) | s_n};
        ovf_q <= m_n[MANT_W-2] && int'(e_n) >= 255;
      end
    end
  end
endmodule
